// File: rtl/i2c_target_regs_pkg.sv
// -----------------------------------------------------------------------------
// i2c_target_regs_pkg
// Shared definitions for the I2C target register port: FSM state encoding and
// bus-level ACK/NACK / read-write bit constants. The controller side can import
// the same package so both ends agree on bit meanings.
// -----------------------------------------------------------------------------
package i2c_target_regs_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_t;

   localparam logic C_ACK     = 1'b0;   // SDA level meaning acknowledge
   localparam logic C_NACK    = 1'b1;   // SDA level meaning not-acknowledge
   localparam logic C_RW_READ = 1'b1;   // R/W bit value for a read transfer

endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_target_regs_bus_sync
// Brings asynchronous SCL/SDA into the clk domain (2-FF synchronizer plus a
// previous-sample register) and derives SCL edges and START/STOP conditions.
// Ports:
//   clk, aresetn      clock, async active-low reset
//   scl_i, sda_i      raw bus lines
//   sda               synchronized SDA level
//   scl_rise/scl_fall 1-cycle SCL edge pulses
//   start/stop        1-cycle START (SDA fall, SCL high) / STOP (SDA rise, SCL high)
// -----------------------------------------------------------------------------
module i2c_target_regs_bus_sync (
   input  logic clk,
   input  logic aresetn,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic scl_m, scl_s, scl_p;
   logic sda_m, sda_s, sda_p;

   // Reset to the idle-bus level (both high) so leaving reset never fakes an edge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         scl_p <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
         sda_p <= 1'b1;
      end else begin
         scl_m <= scl_i;
         scl_s <= scl_m;
         scl_p <= scl_s;
         sda_m <= sda_i;
         sda_s <= sda_m;
         sda_p <= sda_s;
      end
   end

   assign sda      = sda_s;
   assign scl_rise = scl_s & ~scl_p;
   assign scl_fall = ~scl_s & scl_p;
   // SCL must be high in both samples so an SDA change at an SCL edge is not a condition.
   assign start    = sda_p & ~sda_s & scl_s & scl_p;
   assign stop     = ~sda_p & sda_s & scl_s & scl_p;

endmodule

// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
// I2C target with a byte-addressed register port. A write transfer's first data
// byte loads the register pointer; further bytes are written at the pointer with
// auto-increment. A read transfer returns bytes from the pointer, auto-increment.
// No clock stretching, 7-bit addressing only.
// Ports:
//   clk, aresetn             clock, async active-low reset
//   I2C_SCL_I, I2C_SDA_I     bus inputs (asynchronous to clk)
//   I2C_SDA_O, I2C_SDA_OE    open-drain drive: O is always 0, OE=1 pulls SDA low
//   reg_addr_o               register pointer
//   reg_wdata_o, reg_wr_o    write byte and 1-cycle write strobe
//   reg_rdata_i, reg_rd_o    combinational read data for reg_addr_o; 1-cycle
//                            strobe in the cycle after the byte was captured,
//                            reg_addr_o still showing the captured address
//   busy_o                   addressed transfer in progress
//   state_o                  FSM state, for observation
// Strobes are single-cycle pulses with no back-pressure: user logic must accept
// reg_wr_o and service reg_rdata_i in the same cycle. The pointer advances in
// the cycle after each strobe.
// -----------------------------------------------------------------------------
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0] C_TARGET_ADDR = 7'h50,
   parameter int         C_PTR_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   I2C_SCL_I,
   input  logic                   I2C_SDA_I,
   output logic                   I2C_SDA_O,
   output logic                   I2C_SDA_OE,
   output logic [C_PTR_WIDTH-1:0] reg_addr_o,
   output logic [7:0]             reg_wdata_o,
   output logic                   reg_wr_o,
   input  logic [7:0]             reg_rdata_i,
   output logic                   reg_rd_o,
   output logic                   busy_o,
   output state_t                 state_o
);

   localparam logic [C_PTR_WIDTH-1:0] C_PTR_ONE = 1;

   logic sda, scl_rise, scl_fall, start, stop;

   i2c_target_regs_bus_sync u_sync (
      .clk      (clk),
      .aresetn  (aresetn),
      .scl_i    (I2C_SCL_I),
      .sda_i    (I2C_SDA_I),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   state_t                 state, state_n;
   logic [2:0]             bit_cnt, bit_cnt_n;
   logic [7:0]             shift, shift_n;
   logic [C_PTR_WIDTH-1:0] ptr, ptr_n;
   logic                   phase, phase_n;   // second half of an ACK slot / last read bit sent
   logic                   rw, rw_n;
   logic                   oe, oe_n;
   logic                   wr, wr_n;
   logic                   rd, rd_n;
   logic [7:0]             wdata, wdata_n;
   logic                   busy, busy_n;
   logic [7:0]             byte_in;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         ptr     <= '0;
         phase   <= 1'b0;
         rw      <= 1'b0;
         oe      <= 1'b0;
         wr      <= 1'b0;
         rd      <= 1'b0;
         wdata   <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shift   <= shift_n;
         ptr     <= ptr_n;
         phase   <= phase_n;
         rw      <= rw_n;
         oe      <= oe_n;
         wr      <= wr_n;
         rd      <= rd_n;
         wdata   <= wdata_n;
         busy    <= busy_n;
      end
   end

   assign byte_in = {shift[6:0], sda};

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      phase_n   = phase;
      rw_n      = rw;
      oe_n      = oe;
      wr_n      = 1'b0;
      rd_n      = 1'b0;
      wdata_n   = wdata;
      busy_n    = busy;
      // The pointer steps once after every strobe, which keeps reg_addr_o
      // stable for the whole strobe cycle.
      ptr_n     = (wr || rd) ? ptr + C_PTR_ONE : ptr;

      if (stop) begin
         state_n = ST_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
         phase_n = 1'b0;
      end else if (start) begin
         state_n   = ST_ADDR;
         bit_cnt_n = '0;
         phase_n   = 1'b0;
         oe_n      = 1'b0;
      end else begin
         unique case (state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_n   = byte_in;
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ST_ADDR) begin
                        if (byte_in[7:1] == C_TARGET_ADDR) begin
                           state_n = ST_ADDR_ACK;
                           busy_n  = 1'b1;
                           rw_n    = byte_in[0];
                        end else begin
                           state_n = ST_IGNORE;
                           busy_n  = 1'b0;
                        end
                     end else if (state == ST_PTR) begin
                        ptr_n   = byte_in[C_PTR_WIDTH-1:0];
                        state_n = ST_PTR_ACK;
                     end else begin
                        wdata_n = byte_in;
                        wr_n    = 1'b1;
                        state_n = ST_WDATA_ACK;
                     end
                  end
               end
            end

            // First SCL fall: pull SDA for the ACK. Second fall: release
            // (write) or capture the first read byte and drive its MSB.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!phase) begin
                     oe_n    = 1'b1;
                     phase_n = 1'b1;
                  end else begin
                     phase_n   = 1'b0;
                     bit_cnt_n = '0;
                     if (state == ST_ADDR_ACK && rw == C_RW_READ) begin
                        shift_n = {reg_rdata_i[6:0], 1'b0};
                        oe_n    = ~reg_rdata_i[7];
                        rd_n    = 1'b1;
                        state_n = ST_RDATA;
                     end else begin
                        oe_n    = 1'b0;
                        state_n = (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                     end
                  end
               end
            end

            // shift[7] holds the next bit to put on the bus; phase marks
            // that the 8th bit has been clocked out.
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) phase_n = 1'b1;
               end else if (scl_fall) begin
                  if (phase) begin
                     oe_n    = 1'b0;
                     phase_n = 1'b0;
                     state_n = ST_RDATA_ACK;
                  end else begin
                     oe_n    = ~shift[7];
                     shift_n = {shift[6:0], 1'b0};
                  end
               end
            end

            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda == C_NACK) begin
                     state_n = ST_IGNORE;
                     busy_n  = 1'b0;
                  end else begin
                     phase_n = 1'b1;
                  end
               end else if (scl_fall && phase) begin
                  phase_n   = 1'b0;
                  bit_cnt_n = '0;
                  shift_n   = {reg_rdata_i[6:0], 1'b0};
                  oe_n      = ~reg_rdata_i[7];
                  rd_n      = 1'b1;
                  state_n   = ST_RDATA;
               end
            end

            default: ;   // IDLE / IGNORE wait for START
         endcase
      end
   end

   assign I2C_SDA_O   = 1'b0;
   assign I2C_SDA_OE  = oe;
   assign reg_addr_o  = ptr;
   assign reg_wdata_o = wdata;
   assign reg_wr_o    = wr;
   assign reg_rd_o    = rd;
   assign busy_o      = busy;
   assign state_o     = state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regs
// Bench for i2c_target_regs: a bit-banged bus master drives SCL and pulls SDA
// through a wired-AND pull-up model; a small register array acts as user logic.
// Expected register writes and read strobes are queued when stimulus is driven
// and popped when the DUT strobes.
// -----------------------------------------------------------------------------
module tb_i2c_target_regs;
   import i2c_target_regs_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       aresetn;
   logic       scl;
   logic       m_low;
   logic       sda_line;
   logic       sda_o, sda_oe;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy;
   state_t     state;

   assign sda_line = (m_low || (sda_oe && !sda_o)) ? 1'b0 : 1'b1;

   i2c_target_regs #(.C_TARGET_ADDR(7'h50), .C_PTR_WIDTH(4)) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .I2C_SCL_I   (scl),
      .I2C_SDA_I   (sda_line),
      .I2C_SDA_O   (sda_o),
      .I2C_SDA_OE  (sda_oe),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_wr_o    (reg_wr),
      .reg_rdata_i (reg_rdata),
      .reg_rd_o    (reg_rd),
      .busy_o      (busy),
      .state_o     (state)
   );

   // user register file behind the port
   logic [7:0] user_mem [16];
   assign reg_rdata = user_mem[reg_addr];
   always @(posedge clk) if (reg_wr) user_mem[reg_addr] <= reg_wdata;

   // ---------------- scoreboard ----------------
   int pass_cnt = 0;
   int total_cnt = 0;
   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [11:0] exp_w;
   logic [3:0]  exp_r;
   logic        oe_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (sda_oe) oe_seen = 1'b1;
      if (aresetn) begin
         if (reg_wr) begin
            if (wr_q.size() == 0) begin
               total_cnt++;
               $display("FAIL wr_unexpected: addr %0h data %0h, expected no write", reg_addr, reg_wdata);
            end else begin
               exp_w = wr_q.pop_front();
               check("wr_addr_data", {20'd0, reg_addr, reg_wdata}, {20'd0, exp_w});
            end
         end
         if (reg_rd) begin
            if (rd_q.size() == 0) begin
               total_cnt++;
               $display("FAIL rd_unexpected: addr %0h, expected no read strobe", reg_addr);
            end else begin
               exp_r = rd_q.pop_front();
               check("rd_addr", {28'd0, reg_addr}, {28'd0, exp_r});
            end
         end
      end
   end

   // ---------------- bus driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // each bit: SCL low 10 clk (data changes at 5), high 10 clk
   task automatic bit_out(input logic b);
      wait_clk(5); m_low = !b;
      wait_clk(5); scl = 1'b1;
      wait_clk(10); scl = 1'b0;
   endtask

   task automatic bit_in(output logic b);
      wait_clk(5); m_low = 1'b0;
      wait_clk(5); scl = 1'b1;
      wait_clk(5); b = sda_line;
      wait_clk(5); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(nack);
   endtask

   task automatic bus_start();
      if (scl == 1'b0) begin
         wait_clk(5); m_low = 1'b0;
         wait_clk(5); scl = 1'b1;
         wait_clk(10);
      end
      m_low = 1'b1;
      wait_clk(10); scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(5); m_low = 1'b1;
      wait_clk(5); scl = 1'b1;
      wait_clk(10); m_low = 1'b0;
      wait_clk(10);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [6:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       exp_ack;      // level the master sees in the ACK slots
      logic [3:0] exp_wr_addr;
   } vec_t;

   vec_t vecs [4];

   logic       ack;
   logic [7:0] rx;

   initial begin
      vecs[0] = '{7'h50, 8'h0A, 8'h5A, 1'b0, 4'hA};
      vecs[1] = '{7'h51, 8'hFF, 8'hFF, 1'b1, 4'h0};
      vecs[2] = '{7'h50, 8'hF3, 8'h77, 1'b0, 4'h3};
      vecs[3] = '{7'h50, 8'h0C, 8'hC8, 1'b0, 4'hC};

      for (int i = 0; i < 16; i++) user_mem[i] = 8'h00;
      aresetn = 1'b0; scl = 1'b1; m_low = 1'b0; oe_seen = 1'b0;
      wait_clk(3);
      check("rst_oe",    {31'd0, sda_oe},   32'd0);
      check("rst_sda_o", {31'd0, sda_o},    32'd0);
      check("rst_wr",    {31'd0, reg_wr},   32'd0);
      check("rst_rd",    {31'd0, reg_rd},   32'd0);
      check("rst_addr",  {28'd0, reg_addr}, 32'd0);
      check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
      check("rst_busy",  {31'd0, busy},     32'd0);
      check("rst_state", {28'd0, state},    {28'd0, ST_IDLE});
      aresetn = 1'b1;
      wait_clk(5);

      // ---- table-driven single-byte writes ----
      for (int i = 0; i < 4; i++) begin
         oe_seen = 1'b0;
         bus_start();
         send_byte({vecs[i].addr, 1'b0}, ack);
         check("vec_addr_ack", {31'd0, ack}, {31'd0, vecs[i].exp_ack});
         check("vec_busy", {31'd0, busy}, {31'd0, ~vecs[i].exp_ack});
         send_byte(vecs[i].ptr, ack);
         check("vec_ptr_ack", {31'd0, ack}, {31'd0, vecs[i].exp_ack});
         if (!vecs[i].exp_ack) wr_q.push_back({vecs[i].exp_wr_addr, vecs[i].data});
         send_byte(vecs[i].data, ack);
         check("vec_data_ack", {31'd0, ack}, {31'd0, vecs[i].exp_ack});
         bus_stop();
         check("vec_busy_end", {31'd0, busy}, 32'd0);
         check("vec_state_end", {28'd0, state}, {28'd0, ST_IDLE});
         if (vecs[i].exp_ack) check("vec_no_oe", {31'd0, oe_seen}, 32'd0);
      end

      // ---- two data bytes with auto-increment ----
      bus_start();
      send_byte(8'hA0, ack); check("w2_addr_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h05, ack); check("w2_ptr_ack", {31'd0, ack}, 32'd0);
      wr_q.push_back({4'h5, 8'hA5});
      send_byte(8'hA5, ack); check("w2_d0_ack", {31'd0, ack}, 32'd0);
      wr_q.push_back({4'h6, 8'h3C});
      send_byte(8'h3C, ack); check("w2_d1_ack", {31'd0, ack}, 32'd0);
      check("w2_busy", {31'd0, busy}, 32'd1);
      bus_stop();
      check("w2_busy_end", {31'd0, busy}, 32'd0);

      // ---- pointer 0x0F, repeated start, read two bytes across the wrap ----
      user_mem[15] = 8'h11;
      user_mem[0]  = 8'h22;
      bus_start();
      send_byte(8'hA0, ack); check("rd_waddr_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h0F, ack); check("rd_ptr_ack", {31'd0, ack}, 32'd0);
      bus_start();
      rd_q.push_back(4'hF);
      rd_q.push_back(4'h0);
      send_byte(8'hA1, ack); check("rd_raddr_ack", {31'd0, ack}, 32'd0);
      recv_byte(rx, 1'b0); check("rd_byte0", {24'd0, rx}, 32'h11);
      recv_byte(rx, 1'b1); check("rd_byte1", {24'd0, rx}, 32'h22);
      check("rd_nack_state", {28'd0, state}, {28'd0, ST_IGNORE});
      check("rd_nack_busy", {31'd0, busy}, 32'd0);
      bus_stop();
      check("rd_ptr_after", {28'd0, reg_addr}, 32'd1);

      // ---- STOP after 4 bits of a data byte ----
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h08, ack);
      bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
      bus_stop();
      check("part_state", {28'd0, state}, {28'd0, ST_IDLE});
      check("part_busy", {31'd0, busy}, 32'd0);
      check("part_ptr", {28'd0, reg_addr}, 32'd8);
      bus_start();
      send_byte(8'hA0, ack); check("part_next_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h01, ack);
      wr_q.push_back({4'h1, 8'h33});
      send_byte(8'h33, ack); check("part_next_data_ack", {31'd0, ack}, 32'd0);
      bus_stop();

      // ---- reset while driving a read bit ----
      user_mem[2] = 8'h00;
      bus_start();
      send_byte(8'hA0, ack);
      send_byte(8'h02, ack);
      bus_start();
      rd_q.push_back(4'h2);
      send_byte(8'hA1, ack); check("rst_rd_addr_ack", {31'd0, ack}, 32'd0);
      wait_clk(6);
      check("rst_rd_state", {28'd0, state}, {28'd0, ST_RDATA});
      check("rst_rd_oe_on", {31'd0, sda_oe}, 32'd1);
      @(negedge clk);
      aresetn = 1'b0;
      #1;
      check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_addr", {28'd0, reg_addr}, 32'd0);
      check("rst_async_state", {28'd0, state}, {28'd0, ST_IDLE});
      wait_clk(3);
      scl = 1'b1; m_low = 1'b0;
      wait_clk(3);
      aresetn = 1'b1;
      wait_clk(5);
      bus_start();
      send_byte(8'hA0, ack); check("post_rst_addr_ack", {31'd0, ack}, 32'd0);
      send_byte(8'h04, ack);
      wr_q.push_back({4'h4, 8'hE1});
      send_byte(8'hE1, ack); check("post_rst_data_ack", {31'd0, ack}, 32'd0);
      bus_stop();
      check("post_rst_mem", {24'd0, user_mem[4]}, 32'hE1);

      wait_clk(5);
      check("wr_q_empty", wr_q.size(), 32'd0);
      check("rd_q_empty", rd_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
